nor_bus_timed: RTL

Parametrised successor NOR flash bus controller. Sits between a pipelined Wishbone slave port and one or more parallel NOR devices sharing address and data lines. Adds runtime-programmable setup, strobe and hold timing, multiple chip enables decoded from the upper address bits, and per-device RY/BY# polling with a timeout that ends the request with `wb_err_o`. One request is outstanding at a time; the upstream request FIFO stays outside this block.

---
 rtl/nor_bus_pkg.sv | 22 ++
 rtl/nor_timing_counter.sv | 39 +++
 rtl/nor_bus_timed.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nor_bus_pkg.sv
// Shared constants for the timed NOR bus controller: FSM encodings,
// power-up timing defaults and the chip-select index width helper.
package nor_bus_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RDYWAIT = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_ACTIVE  = 3'd3;
  localparam logic [2:0] ST_SAMPLE  = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  localparam int DEF_SETUP   = 0;
  localparam int DEF_WAIT    = 12;
  localparam int DEF_HOLD    = 4;
  localparam int DEF_TIMEOUT = 0;

  // Device index width; a single device still gets one index bit.
  function automatic int calc_csw(input int ncs);
    return (ncs <= 1) ? 1 : $clog2(ncs);
  endfunction

endpackage

// File: rtl/nor_timing_counter.sv
// Loadable down-counter that saturates at zero; done flags the last cycle
// of a phase. Used for both the phase timing and the RY timeout.
module nor_timing_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load has priority over counting down
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/nor_bus_timed.sv
// NOR flash bus controller: pipelined Wishbone slave to shared-bus parallel
// NOR devices with programmable setup/strobe/hold timing and RY/BY# polling.
module nor_bus_timed
  import nor_bus_pkg::*;
#(
  parameter int ADDRBITS = 26,
  parameter int DATABITS = 16,
  parameter int NCS      = 2,
  parameter int CNTBITS  = 8,
  parameter int TOBITS   = 16,
  localparam int CSW     = calc_csw(NCS)
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  input  logic [ADDRBITS+CSW-1:0] wb_adr_i,
  input  logic [DATABITS-1:0]     wb_dat_i,
  output logic [DATABITS-1:0]     wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o,
  input  logic [CNTBITS-1:0]      cfg_setup_i,
  input  logic [CNTBITS-1:0]      cfg_wait_i,
  input  logic [CNTBITS-1:0]      cfg_hold_i,
  input  logic [TOBITS-1:0]       cfg_timeout_i,
  input  logic [NCS-1:0]          nor_ry_i,
  input  logic [DATABITS-1:0]     nor_data_i,
  output logic [DATABITS-1:0]     nor_data_o,
  output logic                    nor_data_oe,
  output logic [ADDRBITS-1:0]     nor_addr_o,
  output logic [NCS-1:0]          nor_ce_o,
  output logic                    nor_we_o,
  output logic                    nor_oe_o
);

  logic [2:0]          state_q, state_d;
  logic [ADDRBITS-1:0] adr_q, adr_d;
  logic [DATABITS-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic                we_q, we_d, abort_q, abort_d, ack_q, ack_d, err_q, err_d;
  logic [CSW-1:0]      idx_q, idx_d;
  logic [CNTBITS-1:0]  s_q, s_d, w_q, w_d, h_q, h_d;
  logic [TOBITS-1:0]   t_q, t_d;
  logic [NCS-1:0]      ce_q, ce_d;
  logic                oe_q, oe_d, wen_q, wen_d, doe_q, doe_d;

  logic               accept_s, bad_idx_s, strobe_s;
  logic               ph_load_s, ph_done_s, to_load_s, to_done_s, to_en_s;
  logic [CNTBITS-1:0] ph_val_s;
  logic [CSW-1:0]     idx_in_s;

  assign idx_in_s  = wb_adr_i[ADDRBITS+CSW-1:ADDRBITS];
  assign accept_s  = wb_cyc_i && wb_stb_i && (state_q == ST_IDLE);
  assign bad_idx_s = (32'(idx_in_s) >= 32'(NCS));
  assign to_en_s   = (state_q == ST_RDYWAIT);

  nor_timing_counter #(.WIDTH(CNTBITS)) u_phase_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (ph_load_s),
    .en       (1'b1),
    .load_val (ph_val_s),
    .done     (ph_done_s)
  );

  // Timeout counter starts at T-1 so done coincides with the T-th RY sample
  nor_timing_counter #(.WIDTH(TOBITS)) u_timeout_cnt (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (to_load_s),
    .en       (to_en_s),
    .load_val (cfg_timeout_i - TOBITS'(1)),
    .done     (to_done_s)
  );

  // Next-state, request latching and next values of the registered bus pins
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    idx_d     = idx_q;
    s_d       = s_q;
    w_d       = w_q;
    h_d       = h_q;
    t_d       = t_q;
    abort_d   = abort_q;
    rdat_d    = rdat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    ph_load_s = 1'b0;
    ph_val_s  = h_q;
    to_load_s = 1'b0;
    strobe_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && bad_idx_s) begin
          err_d = 1'b1;
        end else if (accept_s) begin
          adr_d   = wb_adr_i[ADDRBITS-1:0];
          wdat_d  = wb_dat_i;
          we_d    = wb_we_i;
          idx_d   = idx_in_s;
          s_d     = cfg_setup_i;
          w_d     = cfg_wait_i;
          h_d     = cfg_hold_i;
          t_d     = cfg_timeout_i;
          abort_d = 1'b0;
          if (wb_we_i) begin
            state_d   = ST_RDYWAIT;
            to_load_s = 1'b1;
          end else begin
            state_d   = ST_SETUP;
            ph_load_s = 1'b1;
            ph_val_s  = cfg_setup_i;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RDYWAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (nor_ry_i[idx_q]) begin
          state_d   = ST_SETUP;
          ph_load_s = 1'b1;
          ph_val_s  = s_q;
        end else if ((t_q != '0) && to_done_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_RDYWAIT;
        end
      end
      ST_SETUP, ST_ACTIVE, ST_SAMPLE: begin
        if ((state_q == ST_SAMPLE) && !we_q) begin
          rdat_d = nor_data_i;
        end else begin
          rdat_d = rdat_q;
        end
        // A dropped cycle releases the strobes but still honours the hold time
        if (!wb_cyc_i || (state_q == ST_SAMPLE)) begin
          state_d   = ST_HOLD;
          ph_load_s = 1'b1;
          ph_val_s  = h_q;
          abort_d   = abort_q | !wb_cyc_i;
        end else if (ph_done_s && (state_q == ST_SETUP)) begin
          state_d   = ST_ACTIVE;
          ph_load_s = 1'b1;
          ph_val_s  = w_q;
        end else if (ph_done_s) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        abort_d = abort_q | !wb_cyc_i;
        if (ph_done_s) begin
          state_d = ST_IDLE;
          ack_d   = wb_cyc_i && !abort_q;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    strobe_s = (state_d == ST_ACTIVE) || (state_d == ST_SAMPLE);
    ce_d     = '1;
    if (strobe_s) begin
      ce_d[idx_d] = 1'b0;
    end else begin
      ce_d = '1;
    end
    oe_d  = !(strobe_s && !we_d);
    wen_d = !(strobe_s && we_d);
    doe_d = we_d && ((state_d == ST_SETUP) || (state_d == ST_ACTIVE) ||
                     (state_d == ST_SAMPLE) || (state_d == ST_HOLD));
  end

  // State, latched request and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      s_q     <= CNTBITS'(DEF_SETUP);
      w_q     <= CNTBITS'(DEF_WAIT);
      h_q     <= CNTBITS'(DEF_HOLD);
      t_q     <= TOBITS'(DEF_TIMEOUT);
      abort_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= '1;
      oe_q    <= 1'b1;
      wen_q   <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      s_q     <= s_d;
      w_q     <= w_d;
      h_q     <= h_d;
      t_q     <= t_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wen_q   <= wen_d;
      doe_q   <= doe_d;
    end
  end

  assign wb_dat_o    = rdat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_stall_o  = (state_q != ST_IDLE);
  assign nor_data_o  = wdat_q;
  assign nor_data_oe = doe_q;
  assign nor_addr_o  = adr_q;
  assign nor_ce_o    = ce_q;
  assign nor_we_o    = wen_q;
  assign nor_oe_o    = oe_q;

endmodule
